// File: rtl/vga_sync_rx.sv
// Receive-side video timing recovery: pixel coordinates, line/frame geometry measurement
// and a lock indicator for a stream of active-low hsync/vsync plus an active-video strobe.
module vga_sync_rx #(
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic       px_clk,
   input  logic       resetn,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       de_in,
   output logic [9:0] x_px,
   output logic [9:0] y_px,
   output logic       pixel_valid,
   output logic [9:0] h_total,
   output logic [9:0] h_active,
   output logic [9:0] v_total,
   output logic [9:0] v_active,
   output logic       locked,
   output logic       frame_start
);

   typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

   localparam logic [9:0] CntMax  = 10'd1023;
   localparam logic [3:0] LockCnt = 4'(LOCK_FRAMES);

   state_e      state_q;
   logic        hs_q, vs_q, de_q, hs_qq, vs_qq, de_qq;
   logic [9:0]  hcnt_q, pcnt_q, vact_q, first_len_q, first_run_q;
   logic [10:0] vcnt_q;
   logic        first_len_vld_q, first_run_vld_q, frame_bad_q, prev_valid_q;
   logic [3:0]  match_cnt_q;

   logic        hs_fall, vs_fall, de_rise, de_fall, hs_lost, v_lost;
   logic [10:0] line_len_w;
   logic [9:0]  line_len;
   logic [10:0] vcnt_nx;
   logic [9:0]  vact_nx, first_len_nx, first_run_nx, v_total_nx;
   logic        first_len_vld_nx, first_run_vld_nx, bad_nx;
   logic        tuple_eq, frame_ok;
   logic [3:0]  match_inc;

   // The *_nx values are the frame accumulators including this cycle's events but before any
   // vs_fall clear, so a coincident hs_fall/de_fall still belongs to the ending frame.
   always_comb begin
      hs_fall    = hs_qq & ~hs_q;
      vs_fall    = vs_qq & ~vs_q;
      de_rise    = de_q & ~de_qq;
      de_fall    = de_qq & ~de_q;
      hs_lost    = (hcnt_q == CntMax);
      v_lost     = vcnt_q[10];
      line_len_w = {1'b0, hcnt_q} + 11'd1;
      line_len   = line_len_w[10] ? CntMax : line_len_w[9:0];

      vcnt_nx          = vcnt_q;
      vact_nx          = vact_q;
      first_len_nx     = first_len_q;
      first_len_vld_nx = first_len_vld_q;
      first_run_nx     = first_run_q;
      first_run_vld_nx = first_run_vld_q;
      bad_nx           = frame_bad_q;

      if (hs_fall) begin
         if (!vcnt_q[10]) vcnt_nx = vcnt_q + 11'd1;
         if (first_len_vld_q) begin
            if (line_len != first_len_q) bad_nx = 1'b1;
         end else begin
            first_len_nx     = line_len;
            first_len_vld_nx = 1'b1;
         end
      end

      if (de_fall) begin
         if (vact_q != CntMax) vact_nx = vact_q + 10'd1;
         if (first_run_vld_q) begin
            if (pcnt_q != first_run_q) bad_nx = 1'b1;
         end else begin
            first_run_nx     = pcnt_q;
            first_run_vld_nx = 1'b1;
         end
      end

      v_total_nx = vcnt_nx[10] ? CntMax : vcnt_nx[9:0];
      tuple_eq   = (first_len_nx == h_total) && (first_run_nx == h_active) &&
                   (v_total_nx == v_total) && (vact_nx == v_active);
      frame_ok   = prev_valid_q && tuple_eq && !bad_nx;
      match_inc  = match_cnt_q + 4'd1;
   end

   always_ff @(posedge px_clk) begin
      if (!resetn) begin
         hs_q            <= 1'b1;
         vs_q            <= 1'b1;
         de_q            <= 1'b0;
         hs_qq           <= 1'b1;
         vs_qq           <= 1'b1;
         de_qq           <= 1'b0;
         hcnt_q          <= '0;
         pcnt_q          <= '0;
         vcnt_q          <= '0;
         vact_q          <= '0;
         first_len_q     <= '0;
         first_run_q     <= '0;
         first_len_vld_q <= 1'b0;
         first_run_vld_q <= 1'b0;
         frame_bad_q     <= 1'b0;
         state_q         <= StSearch;
         match_cnt_q     <= '0;
         prev_valid_q    <= 1'b0;
         x_px            <= '0;
         y_px            <= '0;
         pixel_valid     <= 1'b0;
         h_total         <= '0;
         h_active        <= '0;
         v_total         <= '0;
         v_active        <= '0;
         locked          <= 1'b0;
         frame_start     <= 1'b0;
      end else begin
         {hs_q, vs_q, de_q}    <= {hsync_in, vsync_in, de_in};
         {hs_qq, vs_qq, de_qq} <= {hs_q, vs_q, de_q};

         if (hs_fall)      hcnt_q <= '0;
         else if (!hs_lost) hcnt_q <= hcnt_q + 10'd1;

         if (de_rise)                        pcnt_q <= 10'd1;
         else if (de_q && pcnt_q != CntMax) pcnt_q <= pcnt_q + 10'd1;

         if (vs_fall) begin
            vcnt_q          <= '0;
            vact_q          <= '0;
            first_len_q     <= '0;
            first_run_q     <= '0;
            first_len_vld_q <= 1'b0;
            first_run_vld_q <= 1'b0;
            frame_bad_q     <= 1'b0;
         end else begin
            vcnt_q          <= vcnt_nx;
            vact_q          <= vact_nx;
            first_len_q     <= first_len_nx;
            first_run_q     <= first_run_nx;
            first_len_vld_q <= first_len_vld_nx;
            first_run_vld_q <= first_run_vld_nx;
            frame_bad_q     <= bad_nx;
         end

         frame_start <= vs_fall;
         pixel_valid <= de_q && (state_q != StSearch);
         if (de_q && (state_q != StSearch)) begin
            x_px <= de_rise ? 10'd0 : pcnt_q;
            y_px <= vs_fall ? 10'd0 : vact_q;
         end else begin
            x_px <= '0;
            y_px <= '0;
         end

         case (state_q)
            StSearch: begin
               if (vs_fall) begin
                  state_q      <= StTrack;
                  match_cnt_q  <= '0;
                  prev_valid_q <= 1'b0;
               end
            end
            StTrack: begin
               if (vs_fall) begin
                  h_total      <= first_len_nx;
                  h_active     <= first_run_nx;
                  v_total      <= v_total_nx;
                  v_active     <= vact_nx;
                  prev_valid_q <= 1'b1;
                  if (frame_ok) begin
                     match_cnt_q <= match_inc;
                     if (match_inc >= LockCnt) begin
                        state_q <= StLocked;
                        locked  <= 1'b1;
                     end
                  end else begin
                     match_cnt_q <= '0;
                  end
               end
            end
            StLocked: begin
               if (vs_fall) begin
                  h_total  <= first_len_nx;
                  h_active <= first_run_nx;
                  v_total  <= v_total_nx;
                  v_active <= vact_nx;
                  if (!frame_ok) begin
                     state_q     <= StTrack;
                     match_cnt_q <= '0;
                     locked      <= 1'b0;
                  end
               end
            end
            default: state_q <= StSearch;
         endcase

         // Loss of sync overrides everything; the latched measurements are kept.
         if (hs_lost || v_lost) begin
            state_q      <= StSearch;
            match_cnt_q  <= '0;
            prev_valid_q <= 1'b0;
            locked       <= 1'b0;
            frame_start  <= 1'b0;
            pixel_valid  <= 1'b0;
            x_px         <= '0;
            y_px         <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced 20x10 clock raster (12x6 visible) so that
// several frames fit in a short run.
module tb_vga_sync_rx;

   localparam int H_TOT = 20;
   localparam int H_ACT = 12;
   localparam int HS0   = 14;
   localparam int HS_W  = 2;
   localparam int V_TOT = 10;
   localparam int V_ACT = 6;
   localparam int VS0   = 7;
   localparam int VS_W  = 2;

   logic       px_clk = 1'b0;
   logic       resetn = 1'b0;
   logic       hsync_in = 1'b1;
   logic       vsync_in = 1'b1;
   logic       de_in = 1'b0;
   logic [9:0] x_px, y_px, h_total, h_active, v_total, v_active;
   logic       pixel_valid, locked, frame_start;

   int checks = 0;
   int failures = 0;

   int cyc = 0, fs_cnt = 0, fs_cyc = 0, pv_cyc = 0, vs_pin_cyc = 0, de_pin_cyc = 0;
   int pv_run = 0, fr_pv = 0, lock_rise_fs = -1;
   int first_x = 0, first_y = 0, last_x = 0, last_y = 0;
   int fr_first_x = -1, fr_first_y = -1, fr_last_x = -1, fr_last_y = -1;
   bit got_first = 0, pv_prev = 0, lk_prev = 0, vs_pin_prev = 1, de_pin_prev = 0;
   bit lock_rise_with_fs = 0;

   always #5 px_clk = ~px_clk;

   vga_sync_rx #(.LOCK_FRAMES(2)) dut (
      .px_clk      (px_clk),
      .resetn      (resetn),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .de_in       (de_in),
      .x_px        (x_px),
      .y_px        (y_px),
      .pixel_valid (pixel_valid),
      .h_total     (h_total),
      .h_active    (h_active),
      .v_total     (v_total),
      .v_active    (v_active),
      .locked      (locked),
      .frame_start (frame_start)
   );

   // Drive one clock of pins, then sample outputs 1 time unit after the edge.
   task automatic drive_cycle(input logic h, input logic v, input logic d);
      if (!v && vs_pin_prev) vs_pin_cyc = cyc + 1;
      if (d && !de_pin_prev) de_pin_cyc = cyc + 1;
      vs_pin_prev = v;
      de_pin_prev = d;
      hsync_in = h;
      vsync_in = v;
      de_in    = d;
      @(posedge px_clk);
      #1;
      cyc++;
      if (frame_start) begin
         fs_cnt++;
         fs_cyc     = cyc;
         fr_pv      = pv_run;
         fr_first_x = first_x;
         fr_first_y = first_y;
         fr_last_x  = last_x;
         fr_last_y  = last_y;
         pv_run     = 0;
         got_first  = 0;
      end
      if (pixel_valid) begin
         if (!pv_prev) pv_cyc = cyc;
         pv_run++;
         last_x = int'(x_px);
         last_y = int'(y_px);
         if (!got_first) begin
            first_x   = int'(x_px);
            first_y   = int'(y_px);
            got_first = 1;
         end
      end
      pv_prev = pixel_valid;
      if (locked && !lk_prev) begin
         lock_rise_fs      = fs_cnt;
         lock_rise_with_fs = frame_start;
      end
      lk_prev = locked;
   endtask

   function automatic logic [2:0] pins(input int line, input int c, input bit coinc);
      logic h, v, d;
      d = (line < V_ACT) && (c < H_ACT);
      h = !(c >= HS0 && c < HS0 + HS_W);
      if (coinc) v = !((line == VS0 && c >= HS0) || (line == VS0 + 1) || (line == VS0 + 2 && c < HS0));
      else       v = !(line >= VS0 && line < VS0 + VS_W);
      return {h, v, d};
   endfunction

   task automatic drive_frame(input int glitch_line, input bit coinc);
      logic [2:0] p;
      int len;
      for (int line = 0; line < V_TOT; line++) begin
         len = (line == glitch_line) ? H_TOT + 1 : H_TOT;
         for (int c = 0; c < len; c++) begin
            p = pins(line, c, coinc);
            drive_cycle(p[2], p[1], p[0]);
         end
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0);
      resetn = 1'b1;
      fs_cnt = 0;
      lock_rise_fs = -1;
      lk_prev = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({x_px, y_px, pixel_valid, h_total, h_active, v_total, v_active, locked, frame_start} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got x=%0d y=%0d pv=%b ht=%0d ha=%0d vt=%0d va=%0d lk=%b fs=%b, want all 0",
                  x_px, y_px, pixel_valid, h_total, h_active, v_total, v_active, locked, frame_start);
      end
   endtask

   task automatic test_nominal_lock();
      for (int f = 0; f < 3; f++) drive_frame(-1, 0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL lock_early: locked=%b after 3 frames, want 0", locked);
      end
      drive_frame(-1, 0);
      checks++;
      if (lock_rise_fs != 4 || !lock_rise_with_fs) begin
         failures++;
         $display("FAIL lock_rise: rose at frame_start #%0d (with pulse=%b), want #4 with pulse=1",
                  lock_rise_fs, lock_rise_with_fs);
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL locked_nominal: locked=%b, want 1", locked);
      end
      checks++;
      if (h_total !== 10'd20 || h_active !== 10'd12) begin
         failures++;
         $display("FAIL h_meas: h_total=%0d h_active=%0d, want 20 12", h_total, h_active);
      end
      checks++;
      if (v_total !== 10'd10 || v_active !== 10'd6) begin
         failures++;
         $display("FAIL v_meas: v_total=%0d v_active=%0d, want 10 6", v_total, v_active);
      end
      checks++;
      if (fs_cyc - vs_pin_cyc != 1) begin
         failures++;
         $display("FAIL fs_latency: frame_start %0d samples after vsync pin fall, want 1",
                  fs_cyc - vs_pin_cyc);
      end
      checks++;
      if (pv_cyc - de_pin_cyc != 1) begin
         failures++;
         $display("FAIL pv_latency: pixel_valid %0d samples after de pin rise, want 1",
                  pv_cyc - de_pin_cyc);
      end
   endtask

   task automatic test_coordinates();
      drive_frame(-1, 0);
      checks++;
      if (fr_first_x != 0 || fr_first_y != 0) begin
         failures++;
         $display("FAIL first_pixel: x=%0d y=%0d, want 0 0", fr_first_x, fr_first_y);
      end
      checks++;
      if (fr_last_x != H_ACT - 1 || fr_last_y != V_ACT - 1) begin
         failures++;
         $display("FAIL last_pixel: x=%0d y=%0d, want %0d %0d", fr_last_x, fr_last_y,
                  H_ACT - 1, V_ACT - 1);
      end
      checks++;
      if (fr_pv != H_ACT * V_ACT) begin
         failures++;
         $display("FAIL pixel_count: %0d valid cycles, want %0d", fr_pv, H_ACT * V_ACT);
      end
   endtask

   task automatic test_line_glitch();
      drive_frame(3, 0);
      checks++;
      if (locked !== 1'b0 || h_total !== 10'd20) begin
         failures++;
         $display("FAIL glitch_unlock: locked=%b h_total=%0d, want 0 20", locked, h_total);
      end
      drive_frame(-1, 0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL glitch_relock_early: locked=%b after 1 clean frame, want 0", locked);
      end
      drive_frame(-1, 0);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL glitch_relock: locked=%b after 2 clean frames, want 1", locked);
      end
   endtask

   task automatic test_sync_loss();
      int lost_at;
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL loss_precond: locked=%b before hsync hold, want 1", locked);
      end
      lost_at = -1;
      for (int i = 0; i < 1100; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         if (lost_at < 0 && !locked && !pixel_valid) lost_at = i;
      end
      checks++;
      if (lost_at < 1000 || lost_at > 1023) begin
         failures++;
         $display("FAIL loss_detect: lock dropped at hold cycle %0d, want within 1000..1023", lost_at);
      end
      checks++;
      if (locked !== 1'b0 || pixel_valid !== 1'b0 || h_total !== 10'd20) begin
         failures++;
         $display("FAIL loss_state: locked=%b pv=%b h_total=%0d, want 0 0 20",
                  locked, pixel_valid, h_total);
      end
      drive_frame(-1, 0);
      checks++;
      if (fr_pv != 0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL loss_search: %0d valid pixels, locked=%b after loss, want 0 0", fr_pv, locked);
      end
      drive_frame(-1, 0);
      drive_frame(-1, 0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL loss_relock_early: locked=%b, want 0", locked);
      end
      drive_frame(-1, 0);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL loss_relock: locked=%b, want 1", locked);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [2:0] p;
      for (int line = 0; line < V_TOT; line++) begin
         for (int c = 0; c < H_TOT; c++) begin
            p = pins(line, c, 0);
            if (line == 3 && c == 6) begin
               resetn = 1'b0;
               drive_cycle(p[2], p[1], p[0]);
               resetn = 1'b1;
               checks++;
               if ({x_px, y_px, pixel_valid, h_total, h_active, v_total, v_active, locked,
                    frame_start} !== '0) begin
                  failures++;
                  $display("FAIL midreset_outputs: x=%0d y=%0d pv=%b ht=%0d lk=%b, want all 0",
                           x_px, y_px, pixel_valid, h_total, locked);
               end
            end else begin
               drive_cycle(p[2], p[1], p[0]);
            end
         end
      end
      checks++;
      if (h_total !== 10'd0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL midreset_search: h_total=%0d locked=%b, want 0 0", h_total, locked);
      end
      drive_frame(-1, 0);
      drive_frame(-1, 0);
      checks++;
      if (locked !== 1'b0 || h_total !== 10'd20) begin
         failures++;
         $display("FAIL midreset_track: locked=%b h_total=%0d, want 0 20", locked, h_total);
      end
      drive_frame(-1, 0);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL midreset_relock: locked=%b, want 1", locked);
      end
   endtask

   task automatic test_coincident();
      do_reset();
      for (int f = 0; f < 4; f++) drive_frame(-1, 1);
      checks++;
      if (v_total !== 10'd10 || v_active !== 10'd6) begin
         failures++;
         $display("FAIL coinc_vmeas: v_total=%0d v_active=%0d, want 10 6", v_total, v_active);
      end
      checks++;
      if (h_total !== 10'd20 || locked !== 1'b1) begin
         failures++;
         $display("FAIL coinc_lock: h_total=%0d locked=%b, want 20 1", h_total, locked);
      end
   endtask

   initial begin
      test_reset();
      test_nominal_lock();
      test_coordinates();
      test_line_glitch();
      test_sync_loss();
      test_reset_mid_frame();
      test_coincident();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
